// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit, one bit per cycle, with pipeline stall
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] Result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic [XLEN:0] madd, dsh, dsub;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot_s, rem_s, fix_res, spec_res;
  logic a_neg, b_neg, dz, ovf, accept;
  always_comb begin
    accept   = state_q == IDLE && start && !flush;
    a_neg    = SrcA[XLEN-1] && (Funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_neg    = SrcB[XLEN-1] && (Funct3 inside {3'b001, 3'b100, 3'b110});
    dz       = Funct3[2] && SrcB == '0;
    ovf      = Funct3[2] && !Funct3[0] && SrcA == {1'b1, {(XLEN-1){1'b0}}} && SrcB == '1;
    spec_res = dz ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);
    // hi:lo is the product register for MUL and the {remainder, quotient} pair for DIV
    madd     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    dsh      = {hi_q, lo_q[XLEN-1]};
    dsub     = dsh - {1'b0, b_q};
    prod     = {hi_q, lo_q};
    prod_s   = (sa_q ^ sb_q) ? -prod : prod;
    quot_s   = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_s    = sa_q ? -hi_q : hi_q;
    fix_res  = f3_q[2] ? (f3_q[1] ? rem_s : quot_s)
                       : (f3_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    if (flush) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (accept) begin
          f3_d    = Funct3;
          sa_d    = a_neg;
          sb_d    = b_neg;
          hi_d    = '0;
          lo_d    = a_neg ? -SrcA : SrcA;
          b_d     = b_neg ? -SrcB : SrcB;
          cnt_d   = CW'(XLEN-1);
          res_d   = (dz || ovf) ? spec_res : res_q;
          state_d = (dz || ovf) ? DONE : (Funct3[2] ? DIV : MUL);
        end
        MUL: begin
          hi_d    = madd[XLEN:1];
          lo_d    = {madd[0], lo_q[XLEN-1:1]};
          cnt_d   = cnt_q - CW'(1);
          state_d = cnt_q == '0 ? FIX : MUL;
        end
        DIV: begin
          hi_d    = dsub[XLEN] ? dsh[XLEN-1:0] : dsub[XLEN-1:0];
          lo_d    = {lo_q[XLEN-2:0], ~dsub[XLEN]};
          cnt_d   = cnt_q - CW'(1);
          state_d = cnt_q == '0 ? FIX : DIV;
        end
        FIX: begin
          res_d   = fix_res;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign stall  = start & ~done;
  assign Result = res_q;
endmodule
